two_port_mem: RTL

TWO_PORT_MEM -- requirements
Module: two_port_mem

---
 rtl/two_port_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/two_port_mem.sv
// Two-port (1W/1R) word memory with per-lane write mask, pipelined read latency
// and a power-on clear engine that zeroes every word after reset release.
package two_port_mem_pkg;
   // Bits needed to represent depth itself, so out-of-range addresses are expressible.
   function automatic int unsigned clogb2(input int unsigned depth);
      int unsigned bits;
      bits = 0;
      for (int i = 0; i < 32; i++)
         if ((depth >> i) != 0) bits = unsigned'(i) + 1;
      return bits;
   endfunction
endpackage

module two_port_mem
   import two_port_mem_pkg::*;
#(
   parameter int unsigned addresses       = 32,
   parameter int unsigned width           = 8,
   parameter int unsigned byteWidth       = 8,
   parameter int unsigned muxFactor       = 0,
   parameter int unsigned readLatency     = 1,
   parameter int unsigned readDuringWrite = 0,
   localparam int unsigned addressWidth   = clogb2(addresses),
   localparam int unsigned lanes          = width / byteWidth
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    writeEnable,
   input  logic [addressWidth-1:0] writeAddress,
   input  logic [width-1:0]        writeData,
   input  logic [lanes-1:0]        writeMask,
   input  logic                    readEnable,
   input  logic [addressWidth-1:0] readAddress,
   output logic [width-1:0]        readData,
   output logic                    readValid,
   output logic                    initBusy
);

   localparam int unsigned indexWidth = (addresses > 1) ? $clog2(addresses) : 1;

   if ((width % byteWidth) != 0 || readLatency == 0 || readLatency > 3 ||
       (muxFactor != 0 && (addresses % muxFactor) != 0)) begin : gBadParams
      $error("two_port_mem: illegal parameter combination");
   end

   typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

   state_t                  state;
   state_t                  stateNext;
   logic [addressWidth-1:0] clearCount;
   logic [width-1:0]        mem [addresses];
   logic                    writeAccept;
   logic                    readAccept;
   logic                    readInRange;
   logic [width-1:0]        readWord_c;
   logic [readLatency-1:0]  pipeValid;
   logic [width-1:0]        pipeData [readLatency];

   // Clear engine: CLEAR walks every address once, RUN is terminal until reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= CLEAR;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         CLEAR:   if (clearCount == addressWidth'(addresses - 1)) stateNext = RUN;
         RUN:     stateNext = RUN;
         default: stateNext = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)              clearCount <= '0;
      else if (state == CLEAR)  clearCount <= clearCount + addressWidth'(1);
   end

   assign initBusy    = (state == CLEAR);
   assign writeAccept = writeEnable && (state == RUN) &&
                        (writeAddress < addressWidth'(addresses));
   assign readAccept  = readEnable && (state == RUN);
   assign readInRange = (readAddress < addressWidth'(addresses));

   // Storage has no reset; its contents come from the clear engine instead.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[indexWidth'(clearCount)] <= '0;
      end else if (writeAccept) begin
         for (int k = 0; k < lanes; k++)
            if (writeMask[k])
               mem[indexWidth'(writeAddress)][k*byteWidth +: byteWidth] <= writeData[k*byteWidth +: byteWidth];
      end
   end

   // Word captured at acceptance; optional bypass of the lanes being written this cycle.
   always_comb begin
      readWord_c = '0;
      if (readInRange) begin
         readWord_c = mem[indexWidth'(readAddress)];
         if (readDuringWrite != 0 && writeAccept && (writeAddress == readAddress)) begin
            for (int k = 0; k < lanes; k++)
               if (writeMask[k])
                  readWord_c[k*byteWidth +: byteWidth] = writeData[k*byteWidth +: byteWidth];
         end
      end
   end

   // Data stages load only behind a valid, so the last stage holds between reads.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pipeValid <= '0;
         for (int i = 0; i < readLatency; i++) pipeData[i] <= '0;
      end else begin
         pipeValid[0] <= readAccept;
         if (readAccept) pipeData[0] <= readWord_c;
         for (int i = 1; i < readLatency; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            if (pipeValid[i-1]) pipeData[i] <= pipeData[i-1];
         end
      end
   end

   assign readValid = pipeValid[readLatency-1];
   assign readData  = pipeData[readLatency-1];

endmodule
